// File: rtl/ptw_mem_port_if.sv
// Downstream 64-bit word port between the PTW memory responder and the memory hierarchy.
interface ptw_mem_port_if #(parameter int PA_WIDTH = 32);
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [PA_WIDTH-1:0] mem_req_addr;
  logic                mem_req_store;
  logic [63:0]         mem_req_data;
  logic                mem_rsp_valid;
  logic [63:0]         mem_rsp_data;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_store, mem_req_data,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_store, mem_req_data,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/ptw_mem_port.sv
// PTW memory responder: serialises PTE reads and atomic A/D read-modify-write marks
// onto a single 64-bit downstream word port.
module ptw_mem_port #(
  parameter int PA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                walk_req_valid,
  input  logic [PA_WIDTH-1:0] walk_req_addr,
  output logic                walk_rsp_valid,
  output logic [63:0]         walk_rsp_data,
  input  logic                mark_valid,
  input  logic                mark_accessed,
  input  logic                mark_dirty,
  input  logic [63:0]         mark_addr,
  output logic                mark_rsp_valid,
  ptw_mem_port_if.master      mem,
  output logic                busy,
  output logic [2:0]          port_state,
  output logic [31:0]         rd_count,
  output logic [31:0]         wr_count
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    RD_ISSUE     = 3'd1,
    RD_WAIT      = 3'd2,
    RMW_RD_ISSUE = 3'd3,
    RMW_RD_WAIT  = 3'd4,
    RMW_WR_ISSUE = 3'd5,
    RMW_WR_WAIT  = 3'd6
  } state_e;

  state_e state, state_next;

  logic                walk_pend, mark_pend;
  logic [PA_WIDTH-4:0] walk_addr_q, mark_addr_q;
  logic                mark_a_q, mark_d_q;
  logic [1:0]          cur_mask;

  logic                walk_go, mark_go, accept, skip_wr, issue_next;
  logic [PA_WIDTH-4:0] go_addr;
  logic [1:0]          go_mask;
  logic [63:0]         mask64;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{walk_req_addr[2:0], mark_addr[63:PA_WIDTH], mark_addr[2:0]};

  // A same-cycle pulse counts as pending so dispatch costs no extra cycle.
  assign walk_go = (state == IDLE) && (walk_pend || walk_req_valid);
  assign mark_go = (state == IDLE) && !walk_go && (mark_pend || mark_valid);
  assign accept  = mem.mem_req_valid && mem.mem_req_ready;

  assign go_addr = walk_go ? (walk_pend ? walk_addr_q : walk_req_addr[PA_WIDTH-1:3])
                           : (mark_pend ? mark_addr_q : mark_addr[PA_WIDTH-1:3]);
  assign go_mask = mark_pend ? {mark_d_q, mark_a_q | mark_d_q}
                             : {mark_dirty, mark_accessed | mark_dirty};

  assign mask64  = {56'd0, cur_mask, 6'd0};
  assign skip_wr = !mem.mem_rsp_data[0] || ((mem.mem_rsp_data & mask64) == mask64);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:         if (walk_go) state_next = RD_ISSUE;
                    else if (mark_go) state_next = RMW_RD_ISSUE;
      RD_ISSUE:     if (accept) state_next = RD_WAIT;
      RD_WAIT:      if (mem.mem_rsp_valid) state_next = IDLE;
      RMW_RD_ISSUE: if (accept) state_next = RMW_RD_WAIT;
      RMW_RD_WAIT:  if (mem.mem_rsp_valid) state_next = skip_wr ? IDLE : RMW_WR_ISSUE;
      RMW_WR_ISSUE: if (accept) state_next = RMW_WR_WAIT;
      RMW_WR_WAIT:  if (mem.mem_rsp_valid) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  assign issue_next = (state_next == RD_ISSUE) || (state_next == RMW_RD_ISSUE) ||
                      (state_next == RMW_WR_ISSUE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      walk_pend         <= 1'b0;
      mark_pend         <= 1'b0;
      walk_addr_q       <= '0;
      mark_addr_q       <= '0;
      mark_a_q          <= 1'b0;
      mark_d_q          <= 1'b0;
      cur_mask          <= 2'b00;
      mem.mem_req_valid <= 1'b0;
      mem.mem_req_addr  <= '0;
      mem.mem_req_store <= 1'b0;
      mem.mem_req_data  <= '0;
      walk_rsp_valid    <= 1'b0;
      walk_rsp_data     <= '0;
      mark_rsp_valid    <= 1'b0;
      rd_count          <= '0;
      wr_count          <= '0;
    end else begin
      state <= state_next;

      // A pulse landing on an already-set latch is a protocol violation and is dropped.
      if (walk_go) walk_pend <= 1'b0;
      else if (walk_req_valid && !walk_pend) begin
        walk_pend   <= 1'b1;
        walk_addr_q <= walk_req_addr[PA_WIDTH-1:3];
      end

      if (mark_go) mark_pend <= 1'b0;
      else if (mark_valid && !mark_pend) begin
        mark_pend   <= 1'b1;
        mark_addr_q <= mark_addr[PA_WIDTH-1:3];
        mark_a_q    <= mark_accessed;
        mark_d_q    <= mark_dirty;
      end

      // Mask is snapshotted at dispatch so a new mark pulse cannot disturb the RMW.
      if (mark_go) cur_mask <= go_mask;
      if (walk_go || mark_go) mem.mem_req_addr <= {go_addr, 3'b000};

      mem.mem_req_valid <= issue_next;
      mem.mem_req_store <= (state_next == RMW_WR_ISSUE);
      if (state == RMW_RD_WAIT && state_next == RMW_WR_ISSUE)
        mem.mem_req_data <= mem.mem_rsp_data | mask64;
      else if (state_next != RMW_WR_ISSUE)
        mem.mem_req_data <= '0;

      walk_rsp_valid <= (state == RD_WAIT) && mem.mem_rsp_valid;
      if (state == RD_WAIT && mem.mem_rsp_valid) walk_rsp_data <= mem.mem_rsp_data;

      mark_rsp_valid <= mem.mem_rsp_valid &&
                        (((state == RMW_RD_WAIT) && skip_wr) || (state == RMW_WR_WAIT));

      if (accept && (state == RD_ISSUE || state == RMW_RD_ISSUE)) rd_count <= rd_count + 32'd1;
      if (accept && state == RMW_WR_ISSUE) wr_count <= wr_count + 32'd1;
    end
  end

  assign busy       = (state != IDLE) || walk_pend || mark_pend;
  assign port_state = state;

endmodule

// File: tb/tb_ptw_mem_port.sv
// Directed bench for ptw_mem_port with a one-cycle-latency memory responder.
module tb_ptw_mem_port;
  logic        clk = 1'b0;
  logic        reset;
  logic        walk_req_valid;
  logic [31:0] walk_req_addr;
  logic        walk_rsp_valid;
  logic [63:0] walk_rsp_data;
  logic        mark_valid, mark_accessed, mark_dirty;
  logic [63:0] mark_addr;
  logic        mark_rsp_valid;
  logic        busy;
  logic [2:0]  port_state;
  logic [31:0] rd_count, wr_count;

  ptw_mem_port_if #(.PA_WIDTH(32)) m ();

  ptw_mem_port #(.PA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .walk_req_valid(walk_req_valid), .walk_req_addr(walk_req_addr),
    .walk_rsp_valid(walk_rsp_valid), .walk_rsp_data(walk_rsp_data),
    .mark_valid(mark_valid), .mark_accessed(mark_accessed), .mark_dirty(mark_dirty),
    .mark_addr(mark_addr), .mark_rsp_valid(mark_rsp_valid),
    .mem(m.master),
    .busy(busy), .port_state(port_state), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // Memory responder: every accepted request is answered the following cycle.
  logic        ready_en, hold_rsp, rsp_pend;
  logic [63:0] pte_val;
  int          walk_rsp_n, mark_rsp_n;
  logic [31:0] last_wr_addr;
  logic [63:0] last_wr_data;

  assign m.mem_req_ready = ready_en;
  assign m.mem_rsp_valid = rsp_pend && !hold_rsp;
  assign m.mem_rsp_data  = m.mem_rsp_valid ? pte_val : 64'd0;

  initial begin
    rsp_pend = 1'b0; walk_rsp_n = 0; mark_rsp_n = 0;
    last_wr_addr = '0; last_wr_data = '0;
  end

  always @(posedge clk) begin
    if (m.mem_req_valid && m.mem_req_ready) begin
      rsp_pend <= 1'b1;
      if (m.mem_req_store) begin
        last_wr_addr <= m.mem_req_addr;
        last_wr_data <= m.mem_req_data;
      end
    end else if (rsp_pend && !hold_rsp) rsp_pend <= 1'b0;
    if (walk_rsp_valid) walk_rsp_n <= walk_rsp_n + 1;
    if (mark_rsp_valid) mark_rsp_n <= mark_rsp_n + 1;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic mark_pulse(input logic [63:0] a, input logic acc, input logic dty);
    mark_valid = 1'b1; mark_addr = a; mark_accessed = acc; mark_dirty = dty;
  endtask

  int w0, m0;

  initial begin
    reset = 1'b1; walk_req_valid = 1'b0; walk_req_addr = '0;
    mark_valid = 1'b0; mark_accessed = 1'b0; mark_dirty = 1'b0; mark_addr = '0;
    ready_en = 1'b1; hold_rsp = 1'b0; pte_val = '0;
    tick; tick; reset = 1'b0; tick;

    chk("rst_state", port_state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_valid", m.mem_req_valid, 0);
    chk("rst_walk_data", walk_rsp_data, 0);
    chk("rst_counts", {rd_count, wr_count}, 0);

    // Walk read; low address bits must be dropped
    pte_val = 64'h0000_0000_2000_0C01;
    walk_req_valid = 1'b1; walk_req_addr = 32'h8000_100F;
    tick; walk_req_valid = 1'b0;                         // cycle 1
    chk("rd_valid", m.mem_req_valid, 1);
    chk("rd_addr", m.mem_req_addr, 32'h8000_1008);
    chk("rd_store", m.mem_req_store, 0);
    chk("rd_data0", m.mem_req_data, 0);
    chk("rd_busy", busy, 1);
    tick;                                                // cycle 2
    chk("walk_rsp_early", walk_rsp_valid, 0);
    tick;                                                // cycle 3
    chk("walk_rsp_c3", walk_rsp_valid, 1);
    chk("walk_rsp_data", walk_rsp_data, 64'h0000_0000_2000_0C01);
    chk("rd_count1", rd_count, 1);
    tick;
    chk("walk_rsp_1cyc", walk_rsp_valid, 0);
    chk("walk_idle", port_state, 0);

    // Mark accessed, write needed
    pte_val = 64'h1;
    mark_pulse(64'h0000_0001_8000_2010, 1'b1, 1'b0);
    tick; mark_valid = 1'b0;                             // cycle 1
    chk("rmw_rd_addr", m.mem_req_addr, 32'h8000_2010);
    chk("rmw_rd_store", m.mem_req_store, 0);
    tick; tick;                                          // cycle 3
    chk("rmw_wr_valid", m.mem_req_valid, 1);
    chk("rmw_wr_store", m.mem_req_store, 1);
    chk("rmw_wr_data", m.mem_req_data, 64'h41);
    chk("rmw_wr_addr", m.mem_req_addr, 32'h8000_2010);
    chk("rmw_wr_state", port_state, 5);
    tick;                                                // cycle 4
    chk("rmw_wait_state", port_state, 6);
    chk("rmw_wait_valid", m.mem_req_valid, 0);
    tick;                                                // cycle 5
    chk("mark_rsp_c5", mark_rsp_valid, 1);
    chk("wr_count1", wr_count, 1);
    chk("rd_count2", rd_count, 2);
    tick;
    chk("mark_rsp_1cyc", mark_rsp_valid, 0);

    // Mark dirty, A and D already set: write skipped
    pte_val = 64'h0000_0000_0012_30C7;
    mark_pulse(64'h8000_2018, 1'b0, 1'b1);
    tick; mark_valid = 1'b0; tick; tick;                 // cycle 3
    chk("skip_mark_rsp_c3", mark_rsp_valid, 1);
    chk("skip_no_wr", m.mem_req_valid, 0);
    chk("skip_wr_count", wr_count, 1);
    tick;

    // Mark dirty with A/D clear: both bits set
    pte_val = 64'h0000_0000_0012_3007;
    mark_pulse(64'h8000_2018, 1'b0, 1'b1);
    tick; mark_valid = 1'b0; tick; tick;                 // cycle 3
    chk("dirty_wr_data", m.mem_req_data, 64'h0000_0000_0012_30C7);
    tick; tick;                                          // cycle 5
    chk("dirty_mark_rsp", mark_rsp_valid, 1);
    chk("wr_count2", wr_count, 2);
    tick;

    // Invalid PTE: no write even though A is clear
    pte_val = 64'h0;
    mark_pulse(64'h8000_2020, 1'b1, 1'b0);
    tick; mark_valid = 1'b0; tick; tick;                 // cycle 3
    chk("inv_mark_rsp", mark_rsp_valid, 1);
    chk("inv_no_wr", m.mem_req_valid, 0);
    tick;
    chk("inv_wr_count", wr_count, 2);
    chk("rd_count5", rd_count, 5);

    // Backpressure: ready low for 4 cycles
    ready_en = 1'b0; pte_val = 64'hABCD;
    walk_req_valid = 1'b1; walk_req_addr = 32'h8000_3000;
    tick; walk_req_valid = 1'b0;                         // cycle 1
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", m.mem_req_valid, 1);
      chk("bp_addr", m.mem_req_addr, 32'h8000_3000);
      chk("bp_store", m.mem_req_store, 0);
      chk("bp_data", m.mem_req_data, 0);
      chk("bp_rd_count", rd_count, 5);
      tick;
    end
    ready_en = 1'b1;                                     // cycle 5
    chk("bp_valid_acc", m.mem_req_valid, 1);
    chk("bp_addr_acc", m.mem_req_addr, 32'h8000_3000);
    tick;                                                // cycle 6
    chk("bp_drop", m.mem_req_valid, 0);
    chk("bp_rd_count6", rd_count, 6);
    tick;                                                // cycle 7
    chk("bp_walk_rsp", walk_rsp_valid, 1);
    chk("bp_walk_data", walk_rsp_data, 64'hABCD);
    tick;

    // Simultaneous walk and mark
    w0 = walk_rsp_n; m0 = mark_rsp_n; pte_val = 64'h1;
    walk_req_valid = 1'b1; walk_req_addr = 32'h8000_4000;
    mark_pulse(64'h8000_5008, 1'b1, 1'b0);
    tick; walk_req_valid = 1'b0; mark_valid = 1'b0;      // cycle 1
    chk("sim_walk_first", m.mem_req_addr, 32'h8000_4000);
    chk("sim_walk_store", m.mem_req_store, 0);
    tick; tick;                                          // cycle 3
    chk("sim_walk_rsp", walk_rsp_valid, 1);
    chk("sim_busy_pend", busy, 1);
    tick;                                                // cycle 4
    chk("sim_mark_rd", {m.mem_req_valid, m.mem_req_store}, 2'b10);
    chk("sim_mark_addr", m.mem_req_addr, 32'h8000_5008);
    tick; tick;                                          // cycle 6
    chk("sim_wr_data", m.mem_req_data, 64'h41);
    tick; tick;                                          // cycle 8
    chk("sim_mark_rsp", mark_rsp_valid, 1);
    tick; tick;
    chk("sim_walk_once", walk_rsp_n - w0, 1);
    chk("sim_mark_once", mark_rsp_n - m0, 1);
    chk("sim_last_wr", {last_wr_addr, last_wr_data}, {32'h8000_5008, 64'h41});
    chk("sim_counts", {rd_count, wr_count}, {32'd8, 32'd3});

    // Reset in RMW_WR_WAIT, then late downstream ack
    pte_val = 64'h07;
    mark_pulse(64'h8000_6000, 1'b0, 1'b1);
    tick; mark_valid = 1'b0; tick; tick;                 // cycle 3
    hold_rsp = 1'b1;
    chk("rst_wr_issue", port_state, 5);
    tick;                                                // cycle 4
    chk("rst_wr_wait", port_state, 6);
    m0 = mark_rsp_n;
    reset = 1'b1;
    tick;                                                // cycle 5
    reset = 1'b0; hold_rsp = 1'b0;
    chk("rst_mid_state", port_state, 0);
    tick; tick;
    chk("late_no_mark_rsp", mark_rsp_valid, 0);
    chk("late_mark_count", mark_rsp_n - m0, 0);
    chk("late_state", port_state, 0);
    chk("late_busy", busy, 0);
    chk("late_counts", {rd_count, wr_count}, 0);
    chk("late_req_valid", m.mem_req_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
